// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-based debounce.
// One row is driven low per slot. Each completed 16-key frame
// is fed to an IDLE/DEBOUNCE/HELD FSM, which emits a single
// onehot press pulse per accepted key.
module keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] onehot,
  output logic [3:0]  key_code,
  output logic        key_held
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_CNT    = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD
  } state_t;

  logic [3:0]    col_meta, col_sync;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    row_idx;
  logic [15:0]   frame_q;
  logic          frame_done;

  state_t        state_q, state_d;
  logic [15:0]   cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   onehot_d;
  logic [3:0]    code_d;
  logic          held_d;
  logic          frame_single;

  function automatic logic [3:0] enc16(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta <= '0;
      col_sync <= '0;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  // Slot timer, row sequencing and frame assembly; frame_done follows the row-3 sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      row_idx    <= '0;
      frame_q    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt                     <= '0;
        row_idx                      <= row_idx + 2'd1;
        frame_q[{row_idx, 2'b00} +: 4] <= ~col_sync;
        frame_done                   <= (row_idx == 2'd3);
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  // Active-low row drive derived from the current row index
  always_comb begin
    row = ~(4'b0001 << row_idx);
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      onehot   <= '0;
      key_code <= '0;
      key_held <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      onehot   <= onehot_d;
      key_code <= code_d;
      key_held <= held_d;
    end
  end

  // Next-state logic; the FSM only advances on a completed frame.
  // The counter is shared: press count in DEBOUNCE, release count in HELD.
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    onehot_d     = '0;
    code_d       = key_code;
    held_d       = key_held;
    frame_single = (frame_q != '0) && ((frame_q & (frame_q - 16'd1)) == '0);
    if (frame_done) begin
      unique case (state_q)
        S_IDLE: begin
          if (frame_single) begin
            cand_d = frame_q;
            if (DEBOUNCE == 1) begin
              onehot_d = frame_q;
              code_d   = enc16(frame_q);
              held_d   = 1'b1;
              cnt_d    = '0;
              state_d  = S_HELD;
            end else begin
              cnt_d   = CW'(1);
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (frame_q == cand_q) begin
            if (cnt_q + CW'(1) == DB_CNT) begin
              onehot_d = cand_q;
              code_d   = enc16(cand_q);
              held_d   = 1'b1;
              cnt_d    = '0;
              state_d  = S_HELD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          if (frame_q == '0) begin
            if (cnt_q + CW'(1) == DB_CNT) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural keypad matrix model
// and a scoreboard of expected press pulses.
module tb_keypad_scan;

  localparam int SD      = 4;
  localparam int DB      = 2;
  localparam int FRAME   = 4 * SD;
  localparam int LAT     = (DB + 1) * 4 * SD + 4;
  localparam int LAT_ANY = LAT + FRAME;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] onehot;
  logic [3:0]  key_code;
  logic        key_held;

  logic [15:0] keys = '0;
  logic        mon_en = 1'b0;

  typedef struct {
    logic [15:0] oh;
    logic [3:0]  code;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col      (col),
    .row      (row),
    .onehot   (onehot),
    .key_code (key_code),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its column to its row while the row is low
  always_comb begin
    col = '1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [15:0] oh, input logic [3:0] code);
    exp_t e;
    e.oh   = oh;
    e.code = code;
    sb.push_back(e);
  endtask

  task automatic wait_pulse(input string tag, input int p0, input int bound);
    int w;
    w = 0;
    while (pulses == p0 && w < bound) begin
      tick(1);
      w++;
    end
    chk(tag, pulses, p0 + 1);
  endtask

  // Pulse monitor: every nonzero onehot must match the oldest expected press
  always @(negedge clk) begin
    if (mon_en && onehot !== 16'h0000) begin
      pulses++;
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_pulse observed=%0h expected=none", onehot);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_onehot", 32'(onehot), 32'(e.oh));
        chk("pulse_code", 32'(key_code), 32'(e.code));
        chk("pulse_held", 32'(key_held), 32'd1);
      end
    end
  end

  initial begin
    logic [3:0] rows_tab [4];
    int p0;
    rows_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reset for 3 clocks
    rst_n = 1'b0;
    tick(3);
    chk("rst_row", 32'(row), 32'h0000000e);
    chk("rst_onehot", 32'(onehot), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    mon_en = 1'b1;
    rst_n  = 1'b1;

    // Row sequencing, SD clocks per row
    for (int n = 1; n <= 32; n++) begin
      tick(1);
      chk("row_seq", 32'(row), 32'(rows_tab[(n / SD) % 4]));
    end

    // Single press of (2,1), frame-aligned
    p0 = pulses;
    push_exp(16'h0200, 4'd9);
    keys[9] = 1'b1;
    wait_pulse("press21_latency", p0, LAT);
    tick(1);
    chk("press21_held", 32'(key_held), 32'd1);
    tick(20 * FRAME);
    chk("press21_no_repeat", pulses, p0 + 1);
    chk("press21_code_hold", 32'(key_code), 32'd9);
    chk("press21_still_held", 32'(key_held), 32'd1);

    // Release for two frames, then repress
    keys = '0;
    tick(3 * FRAME + 2);
    chk("release_held", 32'(key_held), 32'd0);
    p0 = pulses;
    push_exp(16'h0200, 4'd9);
    keys[9] = 1'b1;
    wait_pulse("repress21", p0, LAT_ANY);
    tick(40);

    // Single-frame release while held must not drop key_held
    p0 = pulses;
    keys = '0;
    tick(FRAME);
    keys[9] = 1'b1;
    tick(3 * FRAME);
    chk("short_release_held", 32'(key_held), 32'd1);
    chk("short_release_no_pulse", pulses, p0);

    // One-clock reset while held; re-acceptance needs full debounce
    p0 = pulses;
    rst_n = 1'b0;
    tick(1);
    chk("midrst_row", 32'(row), 32'h0000000e);
    chk("midrst_held", 32'(key_held), 32'd0);
    chk("midrst_code", 32'(key_code), 32'd0);
    chk("midrst_onehot", 32'(onehot), 32'd0);
    rst_n = 1'b1;
    push_exp(16'h0200, 4'd9);
    tick(2 * FRAME - 2);
    chk("midrst_no_early_pulse", pulses, p0);
    wait_pulse("midrst_repress", p0, LAT);

    // Bounce: (0,3) for a single frame only
    keys = '0;
    tick(4 * FRAME);
    chk("bounce_pre_held", 32'(key_held), 32'd0);
    p0 = pulses;
    keys[3] = 1'b1;
    tick(FRAME);
    keys = '0;
    tick(4 * FRAME);
    chk("bounce_no_pulse", pulses, p0);
    chk("bounce_held", 32'(key_held), 32'd0);

    // Two keys (1,0) and (3,2) together, then release (3,2)
    p0 = pulses;
    keys[4]  = 1'b1;
    keys[14] = 1'b1;
    tick(10 * FRAME);
    chk("twokey_no_pulse", pulses, p0);
    chk("twokey_held", 32'(key_held), 32'd0);
    push_exp(16'h0010, 4'd4);
    keys[14] = 1'b0;
    wait_pulse("twokey_release_pulse", p0, LAT_ANY);
    tick(1);
    chk("twokey_code", 32'(key_code), 32'd4);
    chk("twokey_held_after", 32'(key_held), 32'd1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
